mac_vector_accumulator: RTL and testbench



---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_vector_accumulator_mul.sv | 52 +++++
 rtl/mac_vector_accumulator.sv | 156 +++++++++++++++
 tb/tb_mac_vector_accumulator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC vector accumulator.
// Optional build macro used by the datapath: MAC_SATURATE_EN.
package mac_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 20;
  localparam int unsigned DEF_CNT_W  = 8;

  // Width of the full product of two unsigned operands.
  function automatic int unsigned prod_w(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  // Largest value an acc_w-bit accumulator can hold (acc_w <= 63).
  function automatic logic [63:0] acc_max(input int unsigned acc_w);
    return (64'd1 << acc_w) - 64'd1;
  endfunction

endpackage : mac_pkg

// File: rtl/mac_vector_accumulator_mul.sv
// S1 of the MAC pipeline: registered unsigned multiplier with valid/last
// that holds its contents while the pipeline is stalled.
module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = 2 * DEF_DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_stall,
  input  logic              i_fire,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_last,
  output logic              o_valid,
  output logic              o_last,
  output logic [OUT_W-1:0]  o_prod
);

  localparam int unsigned PROD_W = prod_w(DATA_W);

  logic [PROD_W-1:0] w_prod;
  logic              r_valid;
  logic              r_last;
  logic [OUT_W-1:0]  r_prod;

  // Full-width product of the incoming pair.
  always_comb begin
    w_prod = PROD_W'(i_a) * PROD_W'(i_b);
  end

  // Capture product and last flag on acceptance; freeze everything on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_prod  <= '0;
    end else if (!i_stall) begin
      r_valid <= i_fire;
      if (i_fire) begin
        r_last <= i_last;
        r_prod <= OUT_W'(w_prod);
      end
    end
  end

  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_prod  = r_prod;

endmodule : mac_mul_stage

// File: rtl/mac_vector_accumulator.sv
// Pipelined multiply-accumulate over last-delimited vectors of unsigned pairs.
// Build option: MAC_SATURATE_EN clamps the sum at ACC_MAX on overflow
// instead of wrapping modulo 2^ACC_W.
module mac_vector_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef MAC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
`endif

  logic              r_rdy_en;
  logic              w_stall;
  logic              w_fire;

  logic              w_s1_valid;
  logic              w_s1_last;
  logic [SUM_W-1:0]  w_s1_prod;

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  logic [SUM_W-1:0]  w_sum;
  logic              w_carry;
  logic [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_ovf_next;

  logic              r_fin_valid;
  logic [ACC_W-1:0]  r_fin_acc;
  logic [CNT_W-1:0]  r_fin_cnt;
  logic              r_fin_ovf;

  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_acc;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_out_ovf;

  // Handshake: a held result freezes the whole pipeline and blocks input.
  always_comb begin
    w_stall  = r_out_valid && !out_ready;
    in_ready = r_rdy_en && !w_stall;
    w_fire   = in_valid && in_ready;
  end

  // Input side opens on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  mac_mul_stage #(
    .DATA_W (DATA_W),
    .OUT_W  (SUM_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_stall (w_stall),
    .i_fire  (w_fire),
    .i_a     (in_a),
    .i_b     (in_b),
    .i_last  (in_last),
    .o_valid (w_s1_valid),
    .o_last  (w_s1_last),
    .o_prod  (w_s1_prod)
  );

  // S2 arithmetic: carry-extended add, sticky overflow, saturating count.
  always_comb begin
    w_sum      = {1'b0, r_acc} + w_s1_prod;
    w_carry    = w_sum[ACC_W];
    w_acc_next = w_sum[ACC_W-1:0];
`ifdef MAC_SATURATE_EN
    if (w_carry) begin
      w_acc_next = ACC_MAX;
    end
`endif
    w_ovf_next = r_ovf | w_carry;
    w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // S2 state: running sum per vector; last element hands off and clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_fin_valid <= 1'b0;
      r_fin_acc   <= '0;
      r_fin_cnt   <= '0;
      r_fin_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r_fin_valid <= w_s1_valid && w_s1_last;
      if (w_s1_valid) begin
        if (w_s1_last) begin
          r_fin_acc <= w_acc_next;
          r_fin_cnt <= w_cnt_next;
          r_fin_ovf <= w_ovf_next;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_ovf     <= 1'b0;
        end else begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_next;
          r_ovf <= w_ovf_next;
        end
      end
    end
  end

  // Output register: loads a finished vector, drops valid once taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_cnt   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_fin_valid;
      if (r_fin_valid) begin
        r_out_acc <= r_fin_acc;
        r_out_cnt <= r_fin_cnt;
        r_out_ovf <= r_fin_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_count = r_out_cnt;
  assign out_ovf   = r_out_ovf;

endmodule : mac_vector_accumulator

// File: tb/tb_mac_vector_accumulator.sv
// Directed bench for mac_vector_accumulator: a 20-bit and a 17-bit
// accumulator instance share one stimulus stream.
module tb_mac_vector_accumulator;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 20;
  localparam int unsigned AWS = 17;
  localparam int unsigned CW  = 8;

`ifdef MAC_SATURATE_EN
  localparam int unsigned V4_ACC17 = 131071;
  localparam int unsigned V5_ACC17 = 131071;
`else
  localparam int unsigned V4_ACC17 = 64003;
  localparam int unsigned V5_ACC17 = 64004;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_ready_s;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic           in_last;
  logic           out_valid;
  logic           out_valid_s;
  logic           out_ready;
  logic [AW-1:0]  out_acc;
  logic [AWS-1:0] out_acc_s;
  logic [CW-1:0]  out_count;
  logic [CW-1:0]  out_count_s;
  logic           out_ovf;
  logic           out_ovf_s;

  always #5 clk = ~clk;

  mac_vector_accumulator u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  mac_vector_accumulator #(.ACC_W(AWS)) u_dut17 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_acc   (out_acc_s),
    .out_count (out_count_s),
    .out_ovf   (out_ovf_s)
  );

  typedef struct {
    int unsigned a;
    int unsigned b;
    bit          last;
  } elem_t;

  typedef struct {
    int unsigned acc;
    int unsigned cnt;
    bit          ovf;
    int unsigned acc17;
    bit          ovf17;
  } res_t;

  elem_t elems[$];
  res_t  results[$];
  res_t  exp_q[$];
  res_t  cur;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Present one pair and hold it until it is accepted on a rising edge.
  task automatic send(input int unsigned a, input int unsigned b, input bit last);
    bit got = 1'b0;
    in_a     = DW'(a);
    in_b     = DW'(b);
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL send_timeout: pair %0d*%0d not accepted", a, b);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s: out_valid never rose", name);
    end
  endtask

  // Scoreboard: every accepted result is compared with the next expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got acc %0d with nothing expected", out_acc);
        end else begin
          cur = exp_q.pop_front();
          check("res_acc",   out_acc,     cur.acc);
          check("res_count", out_count,   cur.cnt);
          check("res_ovf",   out_ovf,     cur.ovf);
          check("res_acc17", out_acc_s,   cur.acc17);
          check("res_ovf17", out_ovf_s,   cur.ovf17);
          check("res_cnt17", out_count_s, cur.cnt);
        end
      end
    end
  end

  initial begin
    // Vector table: v0 basic, v1/v2 back-to-back, v3 zeros, v4/v5 overflow, v6 fresh
    elems = '{
      '{3, 4, 0}, '{5, 6, 0}, '{255, 255, 1},
      '{2, 3, 1},
      '{7, 7, 0}, '{1, 1, 1},
      '{0, 9, 0}, '{0, 0, 1},
      '{255, 255, 0}, '{255, 255, 0}, '{255, 255, 1},
      '{255, 255, 0}, '{255, 255, 0}, '{255, 255, 0}, '{0, 0, 0}, '{1, 1, 1},
      '{1, 1, 1}
    };
    results = '{
      '{65067,  3, 0, 65067,    0},
      '{6,      1, 0, 6,        0},
      '{50,     2, 0, 50,       0},
      '{0,      2, 0, 0,        0},
      '{195075, 3, 0, V4_ACC17, 1},
      '{195076, 5, 0, V5_ACC17, 1},
      '{1,      1, 0, 1,        0}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_acc",   out_acc,   0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf",   out_ovf,   0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_clk", in_ready, 0);
    @(posedge clk);
    #1;
    check("ready_after_first_clk", in_ready, 1);

    // Basic vector with latency check
    exp_q.push_back(results[0]);
    for (int i = 0; i < 3; i++) send(elems[i].a, elems[i].b, elems[i].last);
    check("lat_edge_k", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge_k1", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge_k2", out_valid, 1);
    @(posedge clk);
    #1;
    check("valid_drop", out_valid, 0);

    // Remaining table vectors streamed back-to-back
    for (int v = 1; v < results.size(); v++) exp_q.push_back(results[v]);
    for (int i = 3; i < elems.size(); i++) send(elems[i].a, elems[i].b, elems[i].last);
    repeat (6) @(posedge clk);
    #1;
    check("table_drained", exp_q.size(), 0);

    // Backpressure: result held, input blocked with a pair waiting
    exp_q.push_back('{1, 1, 0, 1, 0});
    exp_q.push_back('{26, 2, 0, 26, 0});
    out_ready = 1'b0;
    send(1, 1, 1);
    wait_out_valid("bp_wait");
    in_a     = DW'(2);
    in_b     = DW'(3);
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready",  in_ready,  0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_acc",   out_acc,   1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(4, 5, 1);
    repeat (6) @(posedge clk);
    #1;

    // Count saturation: 300 zero pairs report 255
    exp_q.push_back('{0, 255, 0, 0, 0});
    for (int i = 0; i < 300; i++) send(0, 0, i == 299);
    repeat (6) @(posedge clk);
    #1;

    // Reset mid-vector with a partial sum and a stalled pending result
    out_ready = 1'b0;
    send(9, 9, 1);
    send(10, 10, 0);
    send(10, 10, 0);
    wait_out_valid("pend_wait");
    check("pend_out_acc", out_acc, 81);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_acc",   out_acc,   0);
    check("midrst_in_ready",  in_ready,  0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{4, 1, 0, 4, 0});
    send(2, 2, 1);
    repeat (10) @(posedge clk);
    #1;
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mac_vector_accumulator
